// File: rtl/ntt_feed_ctrl.sv
// ============================================================================
//  Module   : ntt_feed_ctrl
//  Purpose  : Buffers one polynomial from a valid/ready producer, then replays
//             it to the NTTN core as load pulse, gapless burst, gap, start.
//  Options  : NTT_FEED_LENCHK_EN enables s_last length checking (err_len).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ntt_feed_ctrl #(
  parameter int DATA_W    = 32,
  parameter int RING_SIZE = 1024,
  parameter int GAP_CYC   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_inv,
  input  logic              i_s_last,
  output logic              o_load_data,
  output logic              o_start,
  output logic              o_start_intt,
  output logic [DATA_W-1:0] o_din,
  input  logic              i_done,
  output logic              o_busy,
  output logic              o_poly_done,
  output logic              o_err_len
);

  localparam int AW = $clog2(RING_SIZE);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_last_beat = CW'(RING_SIZE - 1);
  localparam logic [CW-1:0] c_ring      = CW'(RING_SIZE);
  localparam logic [CW-1:0] c_drain_end = CW'(RING_SIZE + 1);
  localparam logic [CW-1:0] c_gap_end   = CW'(GAP_CYC);

  typedef enum logic [2:0] {
    S_FILL, S_LOAD, S_BURST, S_GAP, S_START, S_WAIT, S_DRAIN
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_mode;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] r_mem [RING_SIZE];
  logic [AW-1:0]     w_rd_addr;
  logic              w_accept;
  logic              w_len_bad;

  assign o_s_ready = (r_state == S_FILL) && !reset;
  assign w_accept  = i_s_valid && o_s_ready;
  // One counter serves as write index, read index, gap and drain timer.
  assign w_rd_addr = r_cnt[AW-1:0];

`ifdef NTT_FEED_LENCHK_EN
  logic r_err_len;

  assign w_len_bad = i_s_last ? (r_cnt != c_last_beat) : (r_cnt == c_last_beat);

  always_ff @(posedge clk) begin
    if (reset) r_err_len <= 1'b0;
    else       r_err_len <= w_accept && w_len_bad;
  end
  assign o_err_len = r_err_len;
`else
  logic w_unused_last;

  assign w_len_bad     = 1'b0;
  assign w_unused_last = i_s_last;
  assign o_err_len     = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_FILL: begin
        if (w_accept) begin
          if (w_len_bad) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == c_last_beat) begin
            w_state_nxt = S_LOAD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_LOAD: begin
        w_state_nxt = S_BURST;
        w_cnt_nxt   = CW'(1);
      end
      // r_cnt runs one ahead of the word on din so the sync read lands in time.
      S_BURST: begin
        if (r_cnt == c_ring) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = CW'(1);
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == c_gap_end) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_done) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_DRAIN: begin
        if (r_cnt == c_drain_end) begin
          w_state_nxt = S_FILL;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FILL;
      r_cnt   <= '0;
      r_din   <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_din   <= (w_state_nxt == S_BURST) ? r_mem[w_rd_addr] : '0;
      if (w_accept && (r_cnt == '0)) r_mode <= i_s_inv;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_cnt[AW-1:0]] <= i_s_data;
  end

  assign o_din        = r_din;
  assign o_load_data  = (r_state == S_LOAD);
  assign o_start      = (r_state == S_START) && !r_mode;
  assign o_start_intt = (r_state == S_START) && r_mode;
  assign o_busy       = (r_state != S_FILL);
  assign o_poly_done  = (r_state == S_DRAIN) && (r_cnt == c_drain_end);

endmodule

`default_nettype wire
